// File: rtl/sccb_pkg.sv
// Shared types and constants for the write-only SCCB master.
// Bit indices count from 0 at the first transmitted bit of the 27-bit word.
package sccb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_BITS  = 3'd2,
    ST_STOP  = 3'd3,
    ST_GAP   = 3'd4
  } sccb_state_e;

  localparam int SCCB_BITS = 27;

  localparam logic [4:0] DC_BIT0 = 5'd8;
  localparam logic [4:0] DC_BIT1 = 5'd17;
  localparam logic [4:0] DC_BIT2 = 5'd26;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  // Don't-care bits are where the slave would drive its (ignored) response.
  function automatic logic is_dc_bit(input logic [4:0] idx);
    return (idx == DC_BIT0) || (idx == DC_BIT1) || (idx == DC_BIT2);
  endfunction

endpackage

// File: rtl/sccb_qtr_tick.sv
// Quarter-bit timebase: one-clock tick every QTR clocks, realigned when a
// transaction is accepted so START q0 always lasts a full quarter.
module sccb_qtr_tick #(
  parameter int QTR = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int CW = (QTR > 1) ? $clog2(QTR) : 1;
  localparam logic [CW-1:0] LAST = CW'(QTR - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/sccb_master.sv
// Write-only SCCB master: one accepted request becomes one 3-phase write
// (ID+W, sub-address, data) with START/STOP framing and a trailing bus-free gap.
module sccb_master
  import sccb_pkg::*;
#(
  parameter int CLK_FREQ_HZ  = 100_000_000,
  parameter int SCCB_FREQ_HZ = 100_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [6:0] req_id,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_data,
  output logic       busy,
  output logic       done,
  output logic       sioc,
  output logic       siod_o,
  output logic       siod_t
);

  localparam int QTR = CLK_FREQ_HZ / (4 * SCCB_FREQ_HZ);

  if (QTR < 2) begin : g_qtr_check
    $error("sccb_master: CLK_FREQ_HZ/(4*SCCB_FREQ_HZ) must be at least 2");
  end

  // Handshake: a request transfers on a clock where req_valid && req_ready;
  // req_ready is high only in IDLE and inputs are captured on that clock only.
  sccb_state_e state, state_n;
  logic [1:0]  qtr, qtr_n;
  logic [4:0]  bit_cnt, bit_cnt_n;
  logic [26:0] shift, shift_n;
  logic        accept;
  logic        tick;
  logic        sioc_n, siod_o_n, siod_t_n;

  assign accept = req_valid && req_ready;
  assign busy   = ~req_ready;

  sccb_qtr_tick #(.QTR(QTR)) u_qtr_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (accept),
    .tick    (tick)
  );

  always_comb begin
    state_n   = state;
    qtr_n     = qtr;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    if (state == ST_IDLE) begin
      if (accept) begin
        state_n   = ST_START;
        qtr_n     = Q0;
        bit_cnt_n = 5'd0;
        // Don't-care slots hold 1; the line is released during them anyway.
        shift_n   = {req_id, 1'b0, 1'b1, req_addr, 1'b1, req_data, 1'b1};
      end
    end else if (tick) begin
      qtr_n = qtr + 2'd1;
      if (qtr == Q3) begin
        case (state)
          ST_START: begin
            state_n   = ST_BITS;
            bit_cnt_n = 5'd0;
          end
          ST_BITS: begin
            if (bit_cnt == 5'(SCCB_BITS - 1)) begin
              state_n = ST_STOP;
            end else begin
              bit_cnt_n = bit_cnt + 5'd1;
              shift_n   = {shift[25:0], 1'b1};
            end
          end
          ST_STOP: state_n = ST_GAP;
          default: state_n = ST_IDLE;
        endcase
      end
    end
  end

  // Outputs are decoded from the next state and registered, so every pin
  // changes exactly on a quarter boundary with no combinational glitches.
  always_comb begin
    sioc_n   = 1'b1;
    siod_o_n = 1'b1;
    siod_t_n = 1'b1;
    case (state_n)
      ST_START: begin
        sioc_n   = (qtr_n != Q3);
        siod_t_n = 1'b0;
        siod_o_n = (qtr_n == Q0);
      end
      ST_BITS: begin
        sioc_n   = qtr_n[1];
        siod_t_n = is_dc_bit(bit_cnt_n);
        siod_o_n = shift_n[26];
      end
      ST_STOP: begin
        sioc_n   = (qtr_n != Q0);
        siod_t_n = 1'b0;
        siod_o_n = (qtr_n == Q3);
      end
      default: begin
        sioc_n   = 1'b1;
        siod_o_n = 1'b1;
        siod_t_n = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      qtr       <= Q0;
      bit_cnt   <= 5'd0;
      shift     <= '0;
      sioc      <= 1'b1;
      siod_o    <= 1'b1;
      siod_t    <= 1'b1;
      req_ready <= 1'b1;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      qtr       <= qtr_n;
      bit_cnt   <= bit_cnt_n;
      shift     <= shift_n;
      sioc      <= sioc_n;
      siod_o    <= siod_o_n;
      siod_t    <= siod_t_n;
      req_ready <= (state_n == ST_IDLE);
      done      <= (state == ST_STOP) && (state_n == ST_GAP);
    end
  end

endmodule

// File: tb/tb_sccb_master.sv
// Self-checking bench for sccb_master at QTR=2: a bus monitor decodes SIO_C/SIO_D
// frames and compares them, plus handshake timing, against a simple model.
module tb_sccb_master;

  localparam int CLK_FREQ_HZ  = 800;
  localparam int SCCB_FREQ_HZ = 100;
  localparam int QTR          = CLK_FREQ_HZ / (4 * SCCB_FREQ_HZ);
  localparam int TXN_CLKS     = 120 * QTR;
  localparam int DONE_LAT     = 116 * QTR;
  localparam int SIOC_PERIOD  = 4 * QTR;
  localparam int WAIT_LIMIT   = TXN_CLKS + 50;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [6:0] req_id;
  logic [7:0] req_addr;
  logic [7:0] req_data;
  logic       busy;
  logic       done;
  logic       sioc;
  logic       siod_o;
  logic       siod_t;

  sccb_master #(
    .CLK_FREQ_HZ  (CLK_FREQ_HZ),
    .SCCB_FREQ_HZ (SCCB_FREQ_HZ)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_id    (req_id),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .busy      (busy),
    .done      (done),
    .sioc      (sioc),
    .siod_o    (siod_o),
    .siod_t    (siod_t)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [23:0] exp_q[$];
  int starts[$];

  int proto_err = 0, dc_err = 0, per_err = 0, x_err = 0, busy_err = 0;
  int n_done = 0, n_frames = 0, n_start = 0, n_stop = 0, n_complete = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- bus monitor ----------------
  logic        prev_sioc = 1'b1, prev_line = 1'b1, prev_siod_o = 1'b1, prev_ready = 1'b1;
  logic        line, start_c, stop_c, in_frame = 1'b0, in_txn = 1'b0, dc_exp;
  logic [26:0] frame_bits;
  logic [23:0] got_frame;
  int          nbits = 0, last_rise = 0, start_cyc = 0;

  always @(negedge clk) begin
    line = siod_t ? 1'b1 : siod_o;
    if (!rst_n) begin
      in_frame    = 1'b0;
      in_txn      = 1'b0;
      prev_sioc   = 1'b1;
      prev_line   = 1'b1;
      prev_siod_o = 1'b1;
      prev_ready  = 1'b1;
    end else begin
      if ($isunknown({sioc, siod_o, siod_t, req_ready, busy, done})) x_err++;
      if (busy !== !req_ready) busy_err++;
      start_c = prev_sioc && sioc && prev_line && !line;
      stop_c  = prev_sioc && sioc && !prev_line && line;
      if (prev_sioc && sioc && (prev_siod_o != siod_o) && !start_c && !stop_c) proto_err++;
      if (start_c) begin
        in_frame   = 1'b1;
        nbits      = 0;
        frame_bits = '0;
        n_start++;
      end
      if (!prev_sioc && sioc && in_frame && nbits < 27) begin
        frame_bits[26-nbits] = line;
        dc_exp = (nbits == 8) || (nbits == 17) || (nbits == 26);
        if (siod_t !== dc_exp) dc_err++;
        if (nbits > 0 && (cyc - last_rise) != SIOC_PERIOD) per_err++;
        last_rise = cyc;
        nbits++;
      end
      if (stop_c) begin
        n_stop++;
        if (in_frame) begin
          check("bit_count", nbits, 27);
          got_frame = {frame_bits[26:19], frame_bits[17:10], frame_bits[8:1]};
          if (exp_q.size() == 0) check("frame_unexpected", got_frame, 24'h0);
          else check("frame_bytes", got_frame, exp_q.pop_front());
          n_frames++;
        end
        in_frame = 1'b0;
      end
      if (prev_ready && !req_ready) begin
        start_cyc = cyc;
        in_txn    = 1'b1;
        starts.push_back(cyc);
      end
      if (done && in_txn) begin
        check("done_latency", cyc - start_cyc, DONE_LAT);
        n_done++;
      end
      if (!prev_ready && req_ready && in_txn) begin
        check("ready_latency", cyc - start_cyc, TXN_CLKS);
        in_txn = 1'b0;
      end
      prev_sioc   = sioc;
      prev_line   = line;
      prev_siod_o = siod_o;
      prev_ready  = req_ready;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < WAIT_LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("ready_timeout", req_ready, 1'b1);
  endtask

  task automatic send(input logic [6:0] id, input logic [7:0] addr, input logic [7:0] data,
                      input bit churn);
    int n = 0;
    wait_ready();
    req_valid = 1'b1;
    req_id    = id;
    req_addr  = addr;
    req_data  = data;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    exp_q.push_back({id, 1'b0, addr, data});
    if (churn) begin
      while (busy && n < WAIT_LIMIT) begin
        req_id   = 7'($urandom);
        req_addr = 8'($urandom);
        req_data = 8'($urandom);
        @(posedge clk);
        #1;
        n++;
      end
    end
  endtask

  task automatic finish_txn();
    wait_ready();
    repeat (2) @(negedge clk);
    n_complete++;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int s0, d0, st0, sp0;
    logic [6:0] id_a, id_b;
    logic [7:0] ad_a, ad_b, dt_a, dt_b;

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_id    = '0;
    req_addr  = '0;
    req_data  = '0;
    repeat (3) @(negedge clk);
    check("rst_sioc", sioc, 1'b1);
    check("rst_siod_o", siod_o, 1'b1);
    check("rst_siod_t", siod_t, 1'b1);
    check("rst_ready", req_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Directed single write: bytes 0x42, 0x12, 0x80 on the wire.
    st0 = n_start;
    sp0 = n_stop;
    send(7'h21, 8'h12, 8'h80, 1'b0);
    finish_txn();
    check("single_start_seen", n_start - st0, 1);
    check("single_stop_seen", n_stop - sp0, 1);

    // Back-to-back with req_valid held across both acceptances.
    id_a = 7'($urandom); ad_a = 8'($urandom); dt_a = 8'($urandom);
    id_b = 7'($urandom); ad_b = 8'($urandom); dt_b = 8'($urandom);
    s0 = starts.size();
    d0 = n_done;
    wait_ready();
    req_valid = 1'b1;
    req_id = id_a; req_addr = ad_a; req_data = dt_a;
    @(posedge clk);
    #1;
    exp_q.push_back({id_a, 1'b0, ad_a, dt_a});
    req_id = id_b; req_addr = ad_b; req_data = dt_b;
    wait_ready();
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    exp_q.push_back({id_b, 1'b0, ad_b, dt_b});
    finish_txn();
    n_complete++;
    if (starts.size() >= s0 + 2) check("b2b_spacing", starts[s0+1] - starts[s0], TXN_CLKS + 1);
    else check("b2b_start_count", starts.size() - s0, 2);
    check("b2b_done_count", n_done - d0, 2);

    // Random writes with inputs churning every clock while busy.
    for (int i = 0; i < 6; i++) begin
      send(7'($urandom), 8'($urandom), 8'($urandom), 1'b1);
      finish_txn();
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end

    // Reset in the middle of the data bits, then recover.
    send(7'($urandom), 8'($urandom), 8'($urandom), 1'b0);
    repeat (60) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_sioc", sioc, 1'b1);
    check("midrst_siod_t", siod_t, 1'b1);
    check("midrst_ready", req_ready, 1'b1);
    check("midrst_busy", busy, 1'b0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    d0 = n_frames;
    send(7'($urandom), 8'($urandom), 8'($urandom), 1'b0);
    finish_txn();
    check("post_reset_frame", n_frames - d0, 1);

    check("proto_siod_stable", proto_err, 0);
    check("dc_bits_released", dc_err, 0);
    check("sioc_period", per_err, 0);
    check("no_x_outputs", x_err, 0);
    check("busy_is_not_ready", busy_err, 0);
    check("exp_queue_empty", exp_q.size(), 0);
    check("done_count", n_done, n_complete);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
